// File: rtl/mem_link_arbiter.sv
// mem_link_arbiter: round-robin arbiter that packs per-port memory requests
// into byte-serial link packets and returns in-order read responses to the
// port that issued each read.
module mem_link_arbiter #(
  parameter int PORT_COUNT      = 4,
  parameter int DATA_WIDTH_BYTE = 4,
  parameter int ADDR_WIDTH_BYTE = 4,
  parameter int OUTSTANDING     = 4,
  localparam int DATA_WIDTH     = 8 * DATA_WIDTH_BYTE,
  localparam int ADDR_WIDTH     = 8 * ADDR_WIDTH_BYTE,
  localparam int MASK_BYTE      = (DATA_WIDTH_BYTE + 7) / 8,
  localparam int SEND_BYTE      = 1 + MASK_BYTE + ADDR_WIDTH_BYTE + DATA_WIDTH_BYTE,
  localparam int SEND_W         = 8 * SEND_BYTE,
  localparam int LEN_W          = $clog2(SEND_BYTE + 1)
) (
  input  logic                               CLK,
  input  logic                               RST,
  output logic                               send_flag,
  output logic [SEND_W-1:0]                  send_data,
  output logic [LEN_W-1:0]                   send_length,
  input  logic                               sendable,
  output logic                               recv_flag,
  input  logic [SEND_W-1:0]                  recv_data,
  input  logic [LEN_W-1:0]                   recv_length,
  input  logic                               receivable,
  input  logic [2*PORT_COUNT-1:0]            rw_flag_,
  input  logic [ADDR_WIDTH*PORT_COUNT-1:0]   addr_,
  input  logic [DATA_WIDTH*PORT_COUNT-1:0]   write_data_,
  input  logic [DATA_WIDTH_BYTE*PORT_COUNT-1:0] write_mask_,
  output logic [DATA_WIDTH*PORT_COUNT-1:0]   read_data_,
  output logic [PORT_COUNT-1:0]              busy,
  output logic [PORT_COUNT-1:0]              done,
  output logic [PORT_COUNT-1:0]              err
);

  localparam int D  = DATA_WIDTH_BYTE;
  localparam int A  = ADDR_WIDTH_BYTE;
  localparam int PW = $clog2(PORT_COUNT);
  localparam int QW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);

  logic [PORT_COUNT-1:0] pend_vld;
  logic [PORT_COUNT-1:0] pend_wr;
  logic [ADDR_WIDTH-1:0] pend_addr [PORT_COUNT];
  logic [DATA_WIDTH-1:0] pend_data [PORT_COUNT];
  logic [D-1:0]          pend_mask [PORT_COUNT];
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         fifo_mem  [OUTSTANDING];
  logic [QW-1:0]         head;
  logic [QW-1:0]         tail;
  logic [CW-1:0]         count;

  logic [PORT_COUNT-1:0] cap;
  logic                  gnt_vld;
  logic [PW-1:0]         gnt;
  logic [PW:0]           idx;
  logic                  fifo_full;
  logic                  issue;
  logic                  push;
  logic                  resp;
  logic                  pop;
  logic [PW-1:0]         hp;
  logic                  unused_recv;

  // Only the data field of a response is consumed.
  assign unused_recv = ^recv_data[SEND_W-1:DATA_WIDTH];

  function automatic logic [SEND_W-1:0] build_pkt(input logic wr,
                                                  input logic [ADDR_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] d,
                                                  input logic [D-1:0] m);
    logic [SEND_W-1:0]      pkt;
    logic [8*MASK_BYTE-1:0] mz;
    mz        = '0;
    mz[D-1:0] = m;
    pkt       = '0;
    if (wr) pkt = {8'h01, mz, a, d};
    else    pkt[8*(1+A)-1:0] = {8'h00, a};
    return pkt;
  endfunction

  function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
    return (p == QW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full = (count == CW'(OUTSTANDING));
  assign issue     = sendable && !send_flag && gnt_vld;
  assign push      = issue && !pend_wr[gnt];
  assign resp      = receivable && !recv_flag;
  assign pop       = resp && (count != '0);
  assign hp        = fifo_mem[head];

  // Idle ports latch a new read or write request.
  always_comb begin
    for (int p = 0; p < PORT_COUNT; p++)
      cap[p] = !busy[p] && (rw_flag_[2*p +: 2] == 2'd1 || rw_flag_[2*p +: 2] == 2'd2);
  end

  // Round-robin search from rr_ptr; reads are skipped while the FIFO is full.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = '0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(PORT_COUNT)) idx = idx - (PW+1)'(PORT_COUNT);
      if (!gnt_vld && pend_vld[idx[PW-1:0]] && (pend_wr[idx[PW-1:0]] || !fifo_full)) begin
        gnt_vld = 1'b1;
        gnt     = idx[PW-1:0];
      end
    end
  end

  // Control state: request bookkeeping, packet issue, response routing.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      send_flag   <= 1'b0;
      send_data   <= '0;
      send_length <= '0;
      recv_flag   <= 1'b0;
      read_data_  <= '0;
      busy        <= '0;
      done        <= '0;
      err         <= '0;
      pend_vld    <= '0;
      pend_wr     <= '0;
      rr_ptr      <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      send_flag <= issue;
      recv_flag <= resp;
      done      <= '0;
      err       <= '0;
      for (int p = 0; p < PORT_COUNT; p++) begin
        if (cap[p]) begin
          pend_vld[p] <= 1'b1;
          pend_wr[p]  <= (rw_flag_[2*p +: 2] == 2'd2);
          busy[p]     <= 1'b1;
        end
      end
      if (issue) begin
        pend_vld[gnt] <= 1'b0;
        rr_ptr        <= (gnt == PW'(PORT_COUNT - 1)) ? '0 : gnt + 1'b1;
        send_data     <= build_pkt(pend_wr[gnt], pend_addr[gnt], pend_data[gnt], pend_mask[gnt]);
        send_length   <= pend_wr[gnt] ? LEN_W'(SEND_BYTE) : LEN_W'(1 + A);
        if (pend_wr[gnt]) begin
          done[gnt] <= 1'b1;
          busy[gnt] <= 1'b0;
        end
      end
      if (push) tail <= q_inc(tail);
      if (pop) begin
        head     <= q_inc(head);
        done[hp] <= 1'b1;
        busy[hp] <= 1'b0;
        if (recv_length == LEN_W'(D)) begin
          read_data_[int'(hp)*DATA_WIDTH +: DATA_WIDTH] <= recv_data[DATA_WIDTH-1:0];
        end else begin
          read_data_[int'(hp)*DATA_WIDTH +: DATA_WIDTH] <= '0;
          err[hp] <= 1'b1;
        end
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Request payloads and in-flight port tags; qualified by control state.
  always_ff @(posedge CLK) begin
    for (int p = 0; p < PORT_COUNT; p++) begin
      if (cap[p]) begin
        pend_addr[p] <= addr_[p*ADDR_WIDTH +: ADDR_WIDTH];
        pend_data[p] <= write_data_[p*DATA_WIDTH +: DATA_WIDTH];
        pend_mask[p] <= write_mask_[p*D +: D];
      end
    end
    if (push) fifo_mem[tail] <= gnt;
  end

endmodule
